// File: rtl/vec_collect_pkg.sv
// Shared defaults and FSM state type for the vector collector / output-buffer writer.
package vec_collect_pkg;

  localparam int unsigned TILE_SIZE_DEF  = 4;
  localparam int unsigned DATA_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/vec_skid_fifo.sv
// Two-entry registered FIFO; head is visible the cycle after the push that wrote it.
module vec_skid_fifo #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q;
  logic             push_ok, pop_ok;

  assign push_ok   = push && (count_q != 2'd2);
  assign pop_ok    = pop && (count_q != 2'd0);
  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/vec_collect_wr.sv
// Collects biased TILE_SIZE-lane vectors and writes them to sequential output-buffer words.
// Optional ReLU on input lanes when VEC_COLLECT_RELU_EN is defined.
module vec_collect_wr
  import vec_collect_pkg::*;
#(
  parameter int unsigned TILE_SIZE  = TILE_SIZE_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned D          = 256,
  parameter int unsigned ADDR_W     = $clog2(D / TILE_SIZE)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     clear,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic signed [TILE_SIZE-1:0][DATA_WIDTH-1:0] in_vec,
  output logic                                     wr_en,
  input  logic                                     wr_ready,
  output logic [ADDR_W-1:0]                        wr_addr,
  output logic [TILE_SIZE*DATA_WIDTH-1:0]          wr_data,
  output logic                                     done,
  input  logic                                     done_ack
);

  localparam int unsigned VecW     = TILE_SIZE * DATA_WIDTH;
  localparam int unsigned NumWords = D / TILE_SIZE;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NumWords - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [VecW-1:0]   push_data;
  logic [1:0]        fifo_count;
  logic              accept, wr_done, last_wr;

  always_comb begin
    push_data = '0;
    for (int i = 0; i < TILE_SIZE; i++) begin
`ifdef VEC_COLLECT_RELU_EN
      push_data[i*DATA_WIDTH +: DATA_WIDTH] = in_vec[i][DATA_WIDTH-1] ? '0 : in_vec[i];
`else
      push_data[i*DATA_WIDTH +: DATA_WIDTH] = in_vec[i];
`endif
    end
  end

  // rst_n gates in_ready so it reads 0 throughout reset, 1 right after release.
  assign in_ready = rst_n && (fifo_count != 2'd2) && (state_q != StDone);
  assign wr_en    = (fifo_count != 2'd0) && (state_q != StDone);
  assign accept   = in_valid && in_ready;
  assign wr_done  = wr_en && wr_ready;
  assign last_wr  = wr_done && (wr_addr_q == LastAddr);
  assign wr_addr  = wr_addr_q;
  assign done     = (state_q == StDone);

  vec_skid_fifo #(
    .WIDTH (VecW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (clear),
    .push      (accept && !clear),
    .push_data (push_data),
    .pop       (wr_done && !clear),
    .head_data (wr_data),
    .count     (fifo_count)
  );

  always_comb begin
    wr_addr_d = wr_addr_q;
    if (clear) begin
      wr_addr_d = '0;
    end else if (wr_done) begin
      wr_addr_d = (wr_addr_q == LastAddr) ? '0 : wr_addr_q + ADDR_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (accept)   state_d = StRun;
        StRun:   if (last_wr)  state_d = StDone;
        StDone:  if (done_ack) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
    end
  end

endmodule

// File: tb/tb_vec_collect_wr.sv
// Self-checking bench for vec_collect_wr: directed table, corner sequences, random vs queue model.
module tb_vec_collect_wr;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic                     clear = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic signed [3:0][15:0]  in_vec = '0;
  logic                     wr_en;
  logic                     wr_ready = 1'b0;
  logic [5:0]               wr_addr;
  logic [63:0]              wr_data;
  logic                     done;
  logic                     done_ack = 1'b0;

  int errors = 0;
  int checks = 0;

  vec_collect_wr dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_vec   (in_vec),
    .wr_en    (wr_en),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .done     (done),
    .done_ack (done_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] relu(input logic [63:0] v);
    logic [63:0] r;
    r = v;
`ifdef VEC_COLLECT_RELU_EN
    for (int i = 0; i < 4; i++) if (v[i*16+15]) r[i*16 +: 16] = 16'h0000;
`endif
    return r;
  endfunction

  function automatic logic [63:0] mk_vec(input int base);
    logic [63:0] v;
    for (int i = 0; i < 4; i++) v[i*16 +: 16] = 16'(base + i);
    return v;
  endfunction

  // Reference model: a queue of accepted vectors, a frame write index and a frame phase.
  logic [63:0] m_q[$];
  int          m_addr = 0;
  int          m_phase = 0;  // 0 idle, 1 collecting, 2 frame complete
  int          wr_total = 0;

  always @(negedge clk) begin
    bit e_rdy, e_wen, pop, push;
    int nphase;
    if (!rst_n) begin
      m_q.delete();
      m_addr  = 0;
      m_phase = 0;
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      chk("rst_wr_en", 64'(wr_en), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_wr_addr", 64'(wr_addr), 64'(0));
      chk("rst_wr_data", wr_data, 64'(0));
    end else begin
      e_rdy = (m_q.size() < 2) && (m_phase != 2);
      e_wen = (m_q.size() > 0) && (m_phase != 2);
      chk("model_in_ready", 64'(in_ready), 64'(e_rdy));
      chk("model_wr_en", 64'(wr_en), 64'(e_wen));
      chk("model_done", 64'(done), 64'(m_phase == 2));
      chk("model_wr_addr", 64'(wr_addr), 64'(m_addr));
      if (e_wen) chk("model_wr_data", wr_data, m_q[0]);
      if (clear) begin
        m_q.delete();
        m_addr  = 0;
        m_phase = 0;
      end else begin
        pop    = e_wen && wr_ready;
        push   = in_valid && e_rdy;
        nphase = m_phase;
        if (m_phase == 0 && push) nphase = 1;
        if (m_phase == 1 && pop && m_addr == 63) nphase = 2;
        if (m_phase == 2 && done_ack) nphase = 0;
        if (pop) begin
          void'(m_q.pop_front());
          wr_total++;
          m_addr = (m_addr == 63) ? 0 : m_addr + 1;
        end
        if (push) m_q.push_back(relu(64'(in_vec)));
        m_phase = nphase;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input logic [63:0] v);
    int  n;
    bit  got;
    n   = 0;
    got = 1'b0;
    in_valid = 1'b1;
    in_vec   = v;
    while (!got && n < 200) begin
      @(negedge clk);
      got = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    if (!got) chk("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_wr_en;
    int n;
    n = 0;
    @(negedge clk);
    while (!wr_en && n < 50) begin
      tick();
      @(negedge clk);
      n++;
    end
    if (!wr_en) chk("wr_en_timeout", 64'(0), 64'(1));
  endtask

  task automatic drain;
    for (int i = 0; i < 4; i++) tick();
  endtask

  typedef struct {
    bit          vld;
    bit          rdy;
    bit          clr;
    logic [63:0] data;
    bit          e_in_ready;
    bit          e_wr_en;
    int          e_addr;
    logic [63:0] e_data;
  } vec_t;

  initial begin
    vec_t        tbl[9];
    logic [63:0] va, vb, vc, hold_data, neg_vec, neg_exp;
    int          hold_addr, acc, w0, sent, nwait;

    va = mk_vec(100);
    vb = mk_vec(200);
    vc = mk_vec(300);
    tbl[0] = '{1, 0, 0, va, 1, 0, 0, 64'(0)};
    tbl[1] = '{1, 0, 0, vb, 1, 1, 0, va};
    tbl[2] = '{1, 0, 0, vc, 0, 1, 0, va};
    tbl[3] = '{1, 1, 0, vc, 0, 1, 0, va};
    tbl[4] = '{1, 1, 0, vc, 1, 1, 1, vb};
    tbl[5] = '{0, 1, 0, vc, 1, 1, 2, vc};
    tbl[6] = '{0, 1, 0, vc, 1, 0, 3, 64'(0)};
    tbl[7] = '{1, 1, 1, va, 1, 0, 3, 64'(0)};
    tbl[8] = '{0, 1, 0, va, 1, 0, 0, 64'(0)};

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_release", 64'(in_ready), 64'(1));
    tick();

    // Directed table: registered latency, stall hold, pop+push at count 1, clear priority.
    for (int k = 0; k < 9; k++) begin
      in_valid = tbl[k].vld;
      wr_ready = tbl[k].rdy;
      clear    = tbl[k].clr;
      in_vec   = tbl[k].data;
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready", k), 64'(in_ready), 64'(tbl[k].e_in_ready));
      chk($sformatf("tbl%0d_wr_en", k), 64'(wr_en), 64'(tbl[k].e_wr_en));
      chk($sformatf("tbl%0d_wr_addr", k), 64'(wr_addr), 64'(tbl[k].e_addr));
      chk($sformatf("tbl%0d_done", k), 64'(done), 64'(0));
      if (tbl[k].e_wr_en) chk($sformatf("tbl%0d_wr_data", k), wr_data, tbl[k].e_data);
      tick();
    end
    in_valid = 1'b0;
    clear    = 1'b0;

    // Full frame at one vector per cycle.
    wr_ready = 1'b1;
    w0 = wr_total;
    for (int k = 0; k < 64; k++) send_vec(mk_vec(k * 4));
    nwait = 0;
    @(negedge clk);
    while (!done && nwait < 20) begin
      tick();
      @(negedge clk);
      nwait++;
    end
    chk("frame_done", 64'(done), 64'(1));
    chk("frame_writes", 64'(wr_total - w0), 64'(64));
    tick();

    // Held in DONE with upstream valid, then released by done_ack.
    in_valid = 1'b1;
    in_vec   = mk_vec(999);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("done_in_ready", 64'(in_ready), 64'(0));
      chk("done_wr_en", 64'(wr_en), 64'(0));
      chk("done_level", 64'(done), 64'(1));
      tick();
    end
    in_valid = 1'b0;
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
    @(negedge clk);
    chk("ack_done_low", 64'(done), 64'(0));
    chk("ack_in_ready", 64'(in_ready), 64'(1));
    tick();
    send_vec(mk_vec(40));
    wait_wr_en();
    chk("next_frame_addr", 64'(wr_addr), 64'(0));
    tick();

    // Five-cycle output stall with upstream valid.
    for (int k = 1; k < 10; k++) send_vec(mk_vec(40 + k * 4));
    drain();
    wr_ready = 1'b0;
    in_valid = 1'b1;
    acc = 0;
    hold_addr = 0;
    hold_data = '0;
    for (int k = 0; k < 5; k++) begin
      in_vec = mk_vec(500 + k * 4);
      @(negedge clk);
      if (in_ready) acc++;
      if (k == 2) begin
        hold_addr = int'(wr_addr);
        hold_data = wr_data;
      end
      if (k > 2) begin
        chk("stall_addr_hold", 64'(wr_addr), 64'(hold_addr));
        chk("stall_data_hold", wr_data, hold_data);
      end
      tick();
    end
    chk("stall_accepted", 64'(acc), 64'(2));
    in_valid = 1'b0;
    wr_ready = 1'b1;
    drain();
    chk("stall_release_addr", 64'(wr_addr), 64'(12));

    // Clear with two queued words at address 17.
    for (int k = 0; k < 5; k++) send_vec(mk_vec(600 + k * 4));
    drain();
    wr_ready = 1'b0;
    send_vec(mk_vec(700));
    send_vec(mk_vec(704));
    clear    = 1'b1;
    in_valid = 1'b1;
    in_vec   = mk_vec(800);
    @(negedge clk);
    chk("pre_clear_addr", 64'(wr_addr), 64'(17));
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    wr_ready = 1'b1;
    w0 = wr_total;
    @(negedge clk);
    chk("clear_wr_en", 64'(wr_en), 64'(0));
    chk("clear_addr", 64'(wr_addr), 64'(0));
    chk("clear_in_ready", 64'(in_ready), 64'(1));
    tick();
    chk("clear_no_write", 64'(wr_total - w0), 64'(0));

    // Reset in mid-frame.
    for (int k = 0; k < 30; k++) send_vec(mk_vec(k));
    drain();
    chk("pre_reset_addr", 64'(wr_addr), 64'(30));
    in_valid = 1'b1;
    in_vec   = mk_vec(900);
    rst_n    = 1'b0;
    @(negedge clk);
    chk("midrst_wr_addr", 64'(wr_addr), 64'(0));
    chk("midrst_wr_en", 64'(wr_en), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(0));
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    send_vec(mk_vec(5));
    wait_wr_en();
    chk("post_reset_addr", 64'(wr_addr), 64'(0));
    chk("post_reset_data", wr_data, mk_vec(5));
    tick();

    // Negative lanes (-1.0) through the optional ReLU.
    neg_vec = {16'h0003, 16'hFF00, 16'h0001, 16'hFF00};
`ifdef VEC_COLLECT_RELU_EN
    neg_exp = {16'h0003, 16'h0000, 16'h0001, 16'h0000};
`else
    neg_exp = {16'h0003, 16'hFF00, 16'h0001, 16'hFF00};
`endif
    wr_ready = 1'b0;
    send_vec(neg_vec);
    wait_wr_en();
    chk("relu_data", wr_data, neg_exp);
    wr_ready = 1'b1;
    clear    = 1'b1;
    tick();
    clear = 1'b0;
    tick();

    // Random traffic; upstream never exceeds one frame before done_ack.
    sent = 0;
    for (int c = 0; c < 1500; c++) begin
      in_valid = (sent < 64) && ($urandom_range(2) != 0);
      in_vec   = {$urandom, $urandom};
      wr_ready = ($urandom_range(3) != 0);
      done_ack = ($urandom_range(3) == 0);
      clear    = ($urandom_range(299) == 0);
      @(negedge clk);
      if (clear) sent = 0;
      else if (done && done_ack) sent = 0;
      else if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
    done_ack = 1'b0;
    clear    = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
